// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and the conditional-negate helper shared by mdu_iter
package mdu_pkg;
  localparam int MAX_W = 128;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;
  function automatic logic [MAX_W-1:0] cneg(input logic [MAX_W-1:0] x, input logic s);
    return s ? -x : x;
  endfunction
endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/result bundle between the EX stage and mdu_iter
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic start, cancel, busy, done, div_by_zero;
  logic [2:0] op;
  logic [WIDTH-1:0] op1, op2, hi, lo;
  modport master (output start, op, op1, op2, cancel, input busy, done, div_by_zero, hi, lo);
  modport slave (input start, op, op1, op2, cancel, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-divide step (shift in a dividend bit, try subtract)
module mdu_div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] sh;
  // the difference always fits WIDTH bits when the subtract succeeds, since rem < divisor
  always_comb begin
    sh = {rem, q_in};
    q_bit = sh >= {1'b0, divisor};
    rem_next = q_bit ? WIDTH'(sh - {1'b0, divisor}) : sh[WIDTH-1:0];
  end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MDU_FAST_MUL_EN gives single-cycle multiply
module mdu_iter import mdu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst_n,
  mdu_iter_if.slave bus
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] d, r, q, rem_next, a_abs, b_abs, quo, rem, hi_q, lo_q;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] prod;
  logic [MAX_W-1:0] a_x, b_x, prod_x, quo_x, rem_x;
  logic is_div, sgn_q, sgn_r, dz, q_bit, sop, md_op, div_op, busy_q, done_q, dz_q, unused_bits;
  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem(r), .q_in(q[WIDTH-1]), .divisor(d), .rem_next(rem_next), .q_bit(q_bit)
  );
  // operand decode, magnitudes, multiply step and final sign correction
  always_comb begin
    sop = bus.op == OP_MULT || bus.op == OP_DIV;
    div_op = bus.op == OP_DIV || bus.op == OP_DIVU;
    md_op = sop || bus.op == OP_MULTU || bus.op == OP_DIVU;
    a_x = cneg(MAX_W'(bus.op1), sop && bus.op1[WIDTH-1]);
    b_x = cneg(MAX_W'(bus.op2), sop && bus.op2[WIDTH-1]);
    a_abs = a_x[WIDTH-1:0];
    b_abs = b_x[WIDTH-1:0];
    sum = {1'b0, r} + (q[0] ? {1'b0, d} : '0);
    prod_x = cneg(MAX_W'({r, q}), sgn_q);
    quo_x = cneg(MAX_W'(q), sgn_q);
    rem_x = cneg(MAX_W'(r), sgn_r);
    prod = prod_x[2*WIDTH-1:0];
    quo = dz ? '1 : quo_x[WIDTH-1:0];
    rem = rem_x[WIDTH-1:0];
  end
  assign unused_bits = ^{a_x[MAX_W-1:WIDTH], b_x[MAX_W-1:WIDTH], prod_x[MAX_W-1:2*WIDTH],
                         quo_x[MAX_W-1:WIDTH], rem_x[MAX_W-1:WIDTH]};
`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_p;
  logic [MAX_W-1:0] fast_x;
  logic unused_fast;
  assign fast_p = (2*WIDTH)'(a_abs) * (2*WIDTH)'(b_abs);
  assign fast_x = cneg(MAX_W'(fast_p), sop && (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]));
  assign unused_fast = ^fast_x[MAX_W-1:2*WIDTH];
`endif
  // control FSM: capture in IDLE, one radix-2 step per RUN cycle, sign fix and writeback in FIX
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      d <= '0;
      r <= '0;
      q <= '0;
      is_div <= 1'b0;
      sgn_q <= 1'b0;
      sgn_r <= 1'b0;
      dz <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q <= 1'b0;
      case (state)
        ST_IDLE: if (bus.start && !bus.cancel) begin
          if (bus.op == OP_MTHI) begin
            hi_q <= bus.op1;
            done_q <= 1'b1;
          end else if (bus.op == OP_MTLO) begin
            lo_q <= bus.op1;
            done_q <= 1'b1;
`ifdef MDU_FAST_MUL_EN
          end else if (md_op && !div_op) begin
            {hi_q, lo_q} <= fast_x[2*WIDTH-1:0];
            done_q <= 1'b1;
`endif
          end else if (md_op) begin
            state <= ST_RUN;
            busy_q <= 1'b1;
            cnt <= CNT_W'(WIDTH-1);
            is_div <= div_op;
            sgn_q <= sop && (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
            sgn_r <= sop && bus.op1[WIDTH-1];
            dz <= div_op && bus.op2 == '0;
            r <= '0;
            d <= div_op ? b_abs : a_abs;
            q <= div_op ? a_abs : b_abs;
          end
        end
        ST_RUN: if (bus.cancel) begin
          state <= ST_IDLE;
          busy_q <= 1'b0;
        end else begin
          r <= is_div ? rem_next : sum[WIDTH:1];
          q <= is_div ? {q[WIDTH-2:0], q_bit} : {sum[0], q[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= ST_FIX;
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy_q <= 1'b0;
          if (!bus.cancel) begin
            {hi_q, lo_q} <= is_div ? {rem, quo} : prod;
            done_q <= 1'b1;
            dz_q <= dz;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed checks of mdu_iter latency, results, cancel, divide-by-zero and reset
module tb_mdu_iter;
  import mdu_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0;
  int lat, bc, dn, ovl, lastb;
  logic dzv;
  mdu_iter_if #(.WIDTH(W)) bus ();
  mdu_iter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int inj, input logic [2:0] io, input logic [W-1:0] ia, input int can);
    bus.start = 1'b1;
    bus.op = o;
    bus.op1 = a;
    bus.op2 = b;
    bus.cancel = 1'b0;
    lat = 0; bc = 0; dn = 0; ovl = 0; lastb = 0; dzv = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus.busy) begin bc++; lastb = n; end
      if (bus.done) begin
        dn++;
        if (lat == 0) begin lat = n; dzv = bus.div_by_zero; end
      end
      if (bus.busy && bus.done) ovl++;
      if (bus.div_by_zero && !bus.done) ovl++;
      bus.start = n == inj;
      bus.cancel = n == can;
      bus.op = n == inj ? io : o;
      bus.op1 = n == inj ? ia : ~a;
      bus.op2 = ~b;
    end
    bus.start = 1'b0;
    bus.cancel = 1'b0;
  endtask
  task automatic expect_iter(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
    chk({tag, " latency"}, 64'(lat), 64'd34);
    chk({tag, " busy cycles"}, 64'(bc), 64'd33);
    chk({tag, " done count"}, 64'(dn), 64'd1);
    chk({tag, " overlap"}, 64'(ovl), 64'd0);
    chk({tag, " dz"}, 64'(dzv), 64'(edz));
    chk({tag, " hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, " lo"}, 64'(bus.lo), 64'(el));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.op = 3'b000;
    bus.op1 = '0;
    bus.op2 = '0;
    #12;
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset dz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 0, 3'b000, 0, 0);
    expect_iter("mult", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    chk("mult last busy", 64'(lastb), 64'd33);
    run(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 3'b000, 0, 0);
    expect_iter("multu", 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 0, 3'b000, 0, 0);
    expect_iter("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run(OP_DIVU, 32'h0000000A, 32'h00000003, 0, 3'b000, 0, 0);
    expect_iter("divu", 32'h00000001, 32'h00000003, 1'b0);
    run(OP_DIVU, 32'h00000007, 32'h00000000, 0, 3'b000, 0, 0);
    expect_iter("divu by zero", 32'h00000007, 32'hFFFFFFFF, 1'b1);
    run(OP_DIV, 32'hFFFFFFF9, 32'h00000000, 0, 3'b000, 0, 0);
    expect_iter("div by zero", 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 3'b000, 0, 0);
    expect_iter("div overflow", 32'h00000000, 32'h80000000, 1'b0);
    run(OP_MTHI, 32'h00001234, 32'h0, 0, 3'b000, 0, 0);
    chk("mthi latency", 64'(lat), 64'd1);
    chk("mthi busy cycles", 64'(bc), 64'd0);
    chk("mthi done count", 64'(dn), 64'd1);
    chk("mthi hi", 64'(bus.hi), 64'h00001234);
    chk("mthi lo", 64'(bus.lo), 64'h80000000);
    run(3'b110, 32'h00005555, 32'h1, 0, 3'b000, 0, 0);
    chk("reserved done count", 64'(dn), 64'd0);
    chk("reserved busy cycles", 64'(bc), 64'd0);
    chk("reserved hi", 64'(bus.hi), 64'h00001234);
    run(OP_DIVU, 32'd100, 32'd7, 5, OP_MTLO, 32'h0000DEAD, 0);
    expect_iter("divu with mtlo in run", 32'h00000002, 32'h0000000E, 1'b0);
    run(OP_MULT, 32'd5, 32'd6, 0, 3'b000, 0, 10);
    chk("cancel busy cycles", 64'(bc), 64'd10);
    chk("cancel last busy", 64'(lastb), 64'd10);
    chk("cancel done count", 64'(dn), 64'd0);
    chk("cancel hi", 64'(bus.hi), 64'h00000002);
    chk("cancel lo", 64'(bus.lo), 64'h0000000E);
    bus.start = 1'b1;
    bus.op = OP_DIVU;
    bus.op1 = 32'd50;
    bus.op2 = 32'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("pre-reset busy", 64'(bus.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset busy", 64'(bus.busy), 64'd0);
    chk("async reset hi", 64'(bus.hi), 64'd0);
    chk("async reset lo", 64'(bus.lo), 64'd0);
    #2;
    rst_n = 1'b1;
    tick();
    run(OP_MULTU, 32'd3, 32'd5, 0, 3'b000, 0, 0);
    expect_iter("multu after reset", 32'h00000000, 32'h0000000F, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
